// File: rtl/i2c_slave_if.sv
// I2C bus as seen by the slave: scl and resolved sda come from the wire,
// sda_oe is the open-drain pull-down enable driven back onto the line.
interface i2c_slave_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport master (output scl, output sda, input sda_oe);
    modport slave  (input scl, input sda, output sda_oe);
endinterface

// File: rtl/i2c_slave.sv
// 7-bit-address I2C slave: oversampled bus with synchronized edge/condition
// detection, byte receive with auto-ACK, and byte transmit fed by tx_data.
module i2c_slave (
    input  logic        clk,
    input  logic        rs,
    i2c_slave_if.slave  bus,
    input  logic [6:0]  own_add,
    input  logic [7:0]  tx_data,
    output logic        tx_req,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rw_flag,
    output logic        busy,
    output logic [7:0]  byte_ct
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    // [0] metastable stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0] scl_pipe_reg;
    logic [2:0] sda_pipe_reg;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            scl_pipe_reg <= 3'b111;
            sda_pipe_reg <= 3'b111;
        end else begin
            scl_pipe_reg <= {scl_pipe_reg[1:0], bus.scl};
            sda_pipe_reg <= {sda_pipe_reg[1:0], bus.sda};
        end
    end

    logic scl_sync, scl_prev, sda_sync, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_sync  = scl_pipe_reg[1];
    assign scl_prev  = scl_pipe_reg[2];
    assign sda_sync  = sda_pipe_reg[1];
    assign sda_prev  = sda_pipe_reg[2];
    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    // scl must be high in both samples so a simultaneous scl/sda drop is not a START
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

    state_t     state_reg,    state_next;
    logic [2:0] bit_cnt_reg,  bit_cnt_next;
    logic [7:0] shift_reg,    shift_next;
    logic       phase_reg,    phase_next;
    logic       sda_oe_reg,   sda_oe_next;
    logic [7:0] rx_data_reg,  rx_data_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_req_reg,   tx_req_next;
    logic       rw_flag_reg,  rw_flag_next;
    logic [7:0] byte_ct_reg,  byte_ct_next;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            phase_reg    <= 1'b0;
            sda_oe_reg   <= 1'b0;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
            tx_req_reg   <= 1'b0;
            rw_flag_reg  <= 1'b0;
            byte_ct_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            phase_reg    <= phase_next;
            sda_oe_reg   <= sda_oe_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            tx_req_reg   <= tx_req_next;
            rw_flag_reg  <= rw_flag_next;
            byte_ct_reg  <= byte_ct_next;
        end
    end

    // phase_reg: in ACK states, "ACK is being driven"; in TX, "all 8 bits presented"
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        phase_next    = phase_reg;
        sda_oe_next   = sda_oe_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        tx_req_next   = 1'b0;
        rw_flag_next  = rw_flag_reg;
        byte_ct_next  = byte_ct_reg;

        if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 3'd0;
            phase_next   = 1'b0;
            sda_oe_next  = 1'b0;
        end else if (stop_det) begin
            state_next  = IDLE;
            sda_oe_next = 1'b0;
        end else begin
            case (state_reg)
                ADDR, RX: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda_sync};
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            phase_next = 1'b0;
                            if (state_reg == ADDR) begin
                                if (shift_reg[6:0] == own_add) begin
                                    rw_flag_next = sda_sync;
                                    byte_ct_next = 8'h00;
                                    state_next   = ADDR_ACK;
                                end else begin
                                    sda_oe_next = 1'b0;
                                    state_next  = WAIT_STOP;
                                end
                            end else begin
                                rx_data_next  = {shift_reg[6:0], sda_sync};
                                rx_valid_next = 1'b1;
                                byte_ct_next  = byte_ct_reg + 8'd1;
                                state_next    = RX_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    if (scl_fall) begin
                        if (!phase_reg) begin
                            sda_oe_next = 1'b1;
                            phase_next  = 1'b1;
                        end else begin
                            phase_next   = 1'b0;
                            bit_cnt_next = 3'd0;
                            if (state_reg == ADDR_ACK && rw_flag_reg) begin
                                // the falling edge that ends the ACK already carries bit 7
                                shift_next   = {tx_data[6:0], 1'b0};
                                sda_oe_next  = ~tx_data[7];
                                tx_req_next  = 1'b1;
                                bit_cnt_next = 3'd1;
                                state_next   = TX;
                            end else begin
                                sda_oe_next = 1'b0;
                                state_next  = RX;
                            end
                        end
                    end
                end
                TX: begin
                    if (scl_fall) begin
                        if (phase_reg) begin
                            sda_oe_next = 1'b0;
                            phase_next  = 1'b0;
                            state_next  = TX_ACK;
                        end else begin
                            sda_oe_next  = ~shift_reg[7];
                            shift_next   = {shift_reg[6:0], 1'b0};
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7)
                                phase_next = 1'b1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        byte_ct_next = byte_ct_reg + 8'd1;
                        if (!sda_sync) begin
                            shift_next   = tx_data;
                            tx_req_next  = 1'b1;
                            bit_cnt_next = 3'd0;
                            phase_next   = 1'b0;
                            state_next   = TX;
                        end else begin
                            state_next = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe = sda_oe_reg;
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign tx_req     = tx_req_reg;
    assign rw_flag    = rw_flag_reg;
    assign byte_ct    = byte_ct_reg;
    assign busy       = (state_reg != IDLE) && (state_reg != WAIT_STOP);
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bit-banged I2C master on an open-drain line against i2c_slave.
module tb_i2c_slave;
    logic       clk = 1'b0;
    logic       rs  = 1'b0;
    logic [6:0] own_add = 7'h00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req, rx_valid, rw_flag, busy;
    logic [7:0] rx_data, byte_ct;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;

    int vectors = 0;
    int errors  = 0;
    int rx_pulses = 0;
    int tx_pulses = 0;
    int oe_cycles = 0;

    i2c_slave_if bus();
    assign bus.scl = scl_m;
    assign bus.sda = sda_m & ~bus.sda_oe;

    i2c_slave dut (
        .clk      (clk),
        .rs       (rs),
        .bus      (bus),
        .own_add  (own_add),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw_flag  (rw_flag),
        .busy     (busy),
        .byte_ct  (byte_ct)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_pulses++;
        if (tx_req) tx_pulses++;
        if (bus.sda_oe) oe_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; settle();
        scl_m = 1'b1; settle();
        sda_m = 1'b0; settle();
        scl_m = 1'b0; settle();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; settle();
        scl_m = 1'b1; settle();
        sda_m = 1'b1; settle();
    endtask

    // oe_fast: sda_oe three clocks after this bit's falling scl edge
    task automatic write_bit(input logic b, output logic oe_fast);
        sda_m = b;    settle();
        scl_m = 1'b1; settle();
        scl_m = 1'b0;
        repeat (3) @(negedge clk);
        oe_fast = bus.sda_oe;
        repeat (5) @(negedge clk);
    endtask

    task automatic read_bit(output logic b, output logic oe_fast);
        sda_m = 1'b1; settle();
        scl_m = 1'b1; settle();
        b = bus.sda;
        scl_m = 1'b0;
        repeat (3) @(negedge clk);
        oe_fast = bus.sda_oe;
        repeat (5) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack,
                              output logic oe_ack_on, output logic oe_ack_off);
        logic line;
        for (int i = 7; i >= 0; i--) write_bit(d[i], oe_ack_on);
        read_bit(line, oe_ack_off);
        ack = ~line;
        $display("write byte %02h ack=%0b", d, ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic oe;
        for (int i = 7; i >= 0; i--) read_bit(d[i], oe);
        $display("read byte %02h", d);
    endtask

    task automatic test_reset();
        rs = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
        vectors++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        vectors++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
        vectors++; if (rw_flag !== 1'b0) begin errors++; $display("FAIL reset_rw_flag: got %b expected 0", rw_flag); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (byte_ct !== 8'h00) begin errors++; $display("FAIL reset_byte_ct: got %h expected 00", byte_ct); end
        rs = 1'b1;
        settle();
        $display("reset checked");
    endtask

    task automatic test_write();
        logic ack, on, off;
        int r0;
        own_add = 7'b1100101;
        r0 = rx_pulses;
        bus_start();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_start: got %b expected 1", busy); end
        write_byte(8'hCA, ack, on, off);
        vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL write_addr_ack: got %b expected 1", ack); end
        vectors++; if (on !== 1'b1) begin errors++; $display("FAIL write_ack_latency_on: got %b expected 1", on); end
        vectors++; if (off !== 1'b0) begin errors++; $display("FAIL write_ack_latency_off: got %b expected 0", off); end
        vectors++; if (rw_flag !== 1'b0) begin errors++; $display("FAIL write_rw_flag: got %b expected 0", rw_flag); end
        for (int n = 0; n < 3; n++) begin
            write_byte(8'h5A, ack, on, off);
            vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL write_data_ack%0d: got %b expected 1", n, ack); end
            vectors++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL write_rx_data%0d: got %h expected 5a", n, rx_data); end
        end
        vectors++; if (rx_pulses - r0 !== 3) begin errors++; $display("FAIL write_rx_valid_count: got %0d expected 3", rx_pulses - r0); end
        vectors++; if (byte_ct !== 8'd3) begin errors++; $display("FAIL write_byte_ct: got %0d expected 3", byte_ct); end
        bus_stop();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
        vectors++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL write_rx_data_held: got %h expected 5a", rx_data); end
    endtask

    task automatic test_read();
        logic ack, on, off, oe;
        logic [7:0] d;
        int t0;
        own_add = 7'b1011101;
        tx_data = 8'hA5;
        t0 = tx_pulses;
        bus_start();
        write_byte(8'hBB, ack, on, off);
        vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
        vectors++; if (rw_flag !== 1'b1) begin errors++; $display("FAIL read_rw_flag: got %b expected 1", rw_flag); end
        for (int n = 0; n < 3; n++) begin
            read_byte(d);
            vectors++; if (d !== 8'hA5) begin errors++; $display("FAIL read_data%0d: got %h expected a5", n, d); end
            write_bit((n == 2) ? 1'b1 : 1'b0, oe);
        end
        vectors++; if (tx_pulses - t0 !== 3) begin errors++; $display("FAIL read_tx_req_count: got %0d expected 3", tx_pulses - t0); end
        vectors++; if (byte_ct !== 8'd3) begin errors++; $display("FAIL read_byte_ct: got %0d expected 3", byte_ct); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_wait_stop: got %b expected 0", busy); end
        read_byte(d);
        vectors++; if (d !== 8'hFF) begin errors++; $display("FAIL read_ignored_after_nack: got %h expected ff", d); end
        bus_stop();
    endtask

    task automatic test_mismatch();
        logic ack, on, off;
        int r0, o0;
        own_add = 7'b1011101;
        r0 = rx_pulses;
        o0 = oe_cycles;
        bus_start();
        write_byte(8'h12, ack, on, off);
        vectors++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_ack: got %b expected 0", ack); end
        vectors++; if (oe_cycles - o0 !== 0) begin errors++; $display("FAIL mismatch_sda_oe_cycles: got %0d expected 0", oe_cycles - o0); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
        vectors++; if (rx_pulses - r0 !== 0) begin errors++; $display("FAIL mismatch_rx_valid: got %0d expected 0", rx_pulses - r0); end
        bus_stop();
    endtask

    task automatic test_repeated_start();
        logic ack, on, off;
        own_add = 7'b1100101;
        tx_data = 8'hA5;
        bus_start();
        write_byte(8'hCA, ack, on, off);
        write_byte(8'h3C, ack, on, off);
        vectors++; if (byte_ct !== 8'd1) begin errors++; $display("FAIL rstart_byte_ct_before: got %0d expected 1", byte_ct); end
        bus_start();
        write_byte(8'hCB, ack, on, off);
        vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL rstart_read_ack: got %b expected 1", ack); end
        vectors++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rstart_rx_data: got %h expected 3c", rx_data); end
        vectors++; if (rw_flag !== 1'b1) begin errors++; $display("FAIL rstart_rw_flag: got %b expected 1", rw_flag); end
        vectors++; if (byte_ct !== 8'd0) begin errors++; $display("FAIL rstart_byte_ct: got %0d expected 0", byte_ct); end
        bus_stop();
    endtask

    task automatic test_stop_in_rx();
        logic ack, on, off, oe;
        logic [3:0] bits;
        int r0;
        own_add = 7'b1100101;
        bits = 4'b1011;
        r0 = rx_pulses;
        bus_start();
        write_byte(8'hCA, ack, on, off);
        for (int i = 3; i >= 0; i--) write_bit(bits[i], oe);
        bus_stop();
        $display("stop after 4 rx bits");
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL stoprx_busy: got %b expected 0", busy); end
        vectors++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL stoprx_rx_data: got %h expected 3c", rx_data); end
        vectors++; if (rx_pulses - r0 !== 0) begin errors++; $display("FAIL stoprx_rx_valid: got %0d expected 0", rx_pulses - r0); end
    endtask

    task automatic test_reset_mid_read();
        logic ack, on, off, b, oe;
        int o0;
        own_add = 7'b1011101;
        tx_data = 8'hA5;
        bus_start();
        write_byte(8'hBB, ack, on, off);
        read_bit(b, oe);
        vectors++; if (b !== 1'b1) begin errors++; $display("FAIL rstmid_bit7: got %b expected 1", b); end
        vectors++; if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_driving: got %b expected 1", bus.sda_oe); end
        rs = 1'b0;
        #1;
        vectors++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b expected 0", bus.sda_oe); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        #9;
        rs = 1'b1;
        $display("reset pulsed mid-read");
        o0 = oe_cycles;
        for (int i = 0; i < 8; i++) read_bit(b, oe);
        vectors++; if (oe_cycles - o0 !== 0) begin errors++; $display("FAIL rstmid_ignores_bus: got %0d expected 0", oe_cycles - o0); end
        bus_stop();
        bus_start();
        write_byte(8'hBB, ack, on, off);
        vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL rstmid_responds_again: got %b expected 1", ack); end
        bus_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_repeated_start();
        test_stop_in_rx();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
